// File: rtl/char_scroller.sv
// char_scroller: message-buffer glyph walker feeding an external combinational
// glyph ROM and streaming columns over valid/ready at a programmable rate.
// Optional feature macro: CHARSCROLL_REVERSE_EN (adds `dir`, reverse scrolling).
module char_scroller #(
    parameter int FACE_W = 6,
    parameter int IDX_W  = 3,
    parameter int COL_W  = 8,
    parameter int DEPTH  = 16,
    parameter int GAP    = 0,
    parameter int RATE_W = 16,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [AW-1:0]     wr_addr,
    input  logic [FACE_W-1:0] wr_data,
    input  logic [AW:0]       len,
    input  logic              start,
    input  logic              stop,
    input  logic [RATE_W-1:0] rate,
`ifdef CHARSCROLL_REVERSE_EN
    input  logic              dir,
`endif
    output logic [FACE_W-1:0] rom_face,
    output logic [IDX_W-1:0]  rom_index,
    input  logic [COL_W-1:0]  rom_col,
    output logic [COL_W-1:0]  col_data,
    output logic              col_valid,
    input  logic              col_ready,
    output logic              busy,
    output logic              wrap,
    output logic              overrun
);
    // columns per glyph slot (glyph + trailing gap); CW can also hold 2^IDX_W
    localparam int NCOL = 2**IDX_W + GAP;
    localparam int CW   = $clog2(NCOL + 1);
    localparam logic [CW-1:0] LAST_COL   = CW'(NCOL - 1);
    localparam logic [CW-1:0] GLYPH_COLS = CW'(2**IDX_W);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_RUN  = 1'b1;

    logic [0:0]        state;
    logic [FACE_W-1:0] buffer [DEPTH];
    logic [AW-1:0]     char_ptr;
    logic [CW-1:0]     col_ptr;
    logic [AW:0]       len_q;
    logic [RATE_W-1:0] presc;
    logic              rev_q;

    logic start_ok, tick, accept, in_glyph, last_char, wrap_hit;

    assign start_ok  = start && (len != '0) && (len <= (AW+1)'(DEPTH));
    assign tick      = (state == S_RUN) && (presc == rate);
    assign accept    = col_valid && col_ready;
    assign in_glyph  = col_ptr < GLYPH_COLS;
    assign last_char = {1'b0, char_ptr} == (len_q - (AW+1)'(1));
    // wrap marks the end of the full sequence in the current direction
    assign wrap_hit  = rev_q ? (col_ptr == '0 && char_ptr == '0)
                             : (col_ptr == LAST_COL && last_char);

    assign rom_face  = buffer[char_ptr];
    assign rom_index = in_glyph ? col_ptr[IDX_W-1:0] : '0;
    assign busy      = (state == S_RUN);

`ifdef CHARSCROLL_REVERSE_EN
    // direction is captured with each accepted start (stop has priority)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                rev_q <= 1'b0;
        else if (!stop && start_ok) rev_q <= dir;
    end
`else
    assign rev_q = 1'b0;
`endif

    // host write port into the message buffer, usable in any state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) buffer[i] <= '0;
        end else if (wr_en && ({1'b0, wr_addr} < (AW+1)'(DEPTH))) begin
            buffer[wr_addr] <= wr_data;
        end
    end

    // control FSM, prescaler, column generation and handshake
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            char_ptr  <= '0;
            col_ptr   <= '0;
            len_q     <= '0;
            presc     <= '0;
            col_data  <= '0;
            col_valid <= 1'b0;
            wrap      <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            wrap <= 1'b0;
            if (stop) begin
                state     <= S_IDLE;
                col_valid <= 1'b0;
                char_ptr  <= '0;
                col_ptr   <= '0;
                presc     <= '0;
            end else if (start_ok) begin
                state     <= S_RUN;
                len_q     <= len;
                presc     <= '0;
                overrun   <= 1'b0;
                col_valid <= 1'b0;
`ifdef CHARSCROLL_REVERSE_EN
                char_ptr  <= dir ? AW'(len - (AW+1)'(1)) : '0;
                col_ptr   <= dir ? LAST_COL : '0;
`else
                char_ptr  <= '0;
                col_ptr   <= '0;
`endif
            end else if (state == S_RUN) begin
                presc <= tick ? '0 : presc + RATE_W'(1);
                // acceptance wins over a coincident tick: no overrun, no regen
                if (accept) begin
                    col_valid <= 1'b0;
                    wrap      <= wrap_hit;
                    if (!rev_q) begin
                        if (col_ptr == LAST_COL) begin
                            col_ptr  <= '0;
                            char_ptr <= last_char ? '0 : char_ptr + AW'(1);
                        end else begin
                            col_ptr  <= col_ptr + CW'(1);
                        end
                    end else begin
                        if (col_ptr == '0) begin
                            col_ptr  <= LAST_COL;
                            char_ptr <= (char_ptr == '0) ? AW'(len_q - (AW+1)'(1))
                                                         : char_ptr - AW'(1);
                        end else begin
                            col_ptr  <= col_ptr - CW'(1);
                        end
                    end
                end else if (tick) begin
                    if (!col_valid) begin
                        col_data  <= in_glyph ? rom_col : '0;
                        col_valid <= 1'b1;
                    end else begin
                        overrun   <= 1'b1;
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_char_scroller.sv
// Directed bench for char_scroller: one instance with GAP=0, one with GAP=2.
// Glyph ROM model: column = {face[4:0], index}.
module tb_char_scroller;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        wr_en = 1'b0;
    logic [3:0]  wr_addr = '0;
    logic [5:0]  wr_data = '0;
    logic [4:0]  len = '0;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic [15:0] rate = '0;
    logic        col_ready = 1'b0;
`ifdef CHARSCROLL_REVERSE_EN
    logic        dir = 1'b0;
`endif

    logic [5:0] rom_face0, rom_face1;
    logic [2:0] rom_index0, rom_index1;
    logic [7:0] rom_col0, rom_col1, col_data0, col_data1;
    logic       col_valid0, col_valid1, busy0, busy1, wrap0, wrap1, overrun0, overrun1;

    int total = 0;
    int bad = 0;
    int cyc = 0;

    assign rom_col0 = {rom_face0[4:0], rom_index0};
    assign rom_col1 = {rom_face1[4:0], rom_index1};

    char_scroller #(.GAP(0)) u_dut (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .len(len), .start(start), .stop(stop), .rate(rate),
`ifdef CHARSCROLL_REVERSE_EN
        .dir(dir),
`endif
        .rom_face(rom_face0), .rom_index(rom_index0), .rom_col(rom_col0),
        .col_data(col_data0), .col_valid(col_valid0), .col_ready(col_ready),
        .busy(busy0), .wrap(wrap0), .overrun(overrun0));

    char_scroller #(.GAP(2)) u_gap (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .len(len), .start(start), .stop(stop), .rate(rate),
`ifdef CHARSCROLL_REVERSE_EN
        .dir(dir),
`endif
        .rom_face(rom_face1), .rom_index(rom_index1), .rom_col(rom_col1),
        .col_data(col_data1), .col_valid(col_valid1), .col_ready(col_ready),
        .busy(busy1), .wrap(wrap1), .overrun(overrun1));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic wr(input logic [3:0] a, input logic [5:0] d);
        @(negedge clk); wr_en = 1'b1; wr_addr = a; wr_data = d;
        @(negedge clk); wr_en = 1'b0;
    endtask

    task automatic pulse_start(input logic [4:0] l);
        @(negedge clk); len = l; start = 1'b1;
        @(negedge clk); start = 1'b0;
    endtask

    task automatic pulse_stop();
        @(negedge clk); stop = 1'b1;
        @(negedge clk); stop = 1'b0;
    endtask

    task automatic wait_valid(input int which, output bit ok);
        ok = 1'b0;
        for (int n = 0; n < 40; n++) begin
            if ((which == 0) ? col_valid0 : col_valid1) begin ok = 1'b1; break; end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        total++;
        if ({col_data0, col_valid0, busy0, wrap0, overrun0, rom_face0} !== '0) begin
            bad++; $display("FAIL reset_init got data=%h v=%b busy=%b wrap=%b ovr=%b face=%h want all 0",
                            col_data0, col_valid0, busy0, wrap0, overrun0, rom_face0);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_forward();
        bit ok; logic [5:0] f; logic [2:0] ix;
        pulse_stop();
        wr(4'd0, 6'd5); wr(4'd1, 6'd9);
        rate = 16'd0; col_ready = 1'b1;
        pulse_start(5'd2);
        for (int k = 0; k < 24; k++) begin
            f = ((k % 16) < 8) ? 6'd5 : 6'd9;
            ix = 3'(k % 8);
            wait_valid(0, ok);
            total++;
            if (!ok) begin bad++; $display("FAIL fwd_timeout col %0d got valid=0 want 1", k); end
            total++;
            if (col_data0 !== {f[4:0], ix} || rom_face0 !== f || rom_index0 !== ix) begin
                bad++; $display("FAIL fwd_col %0d got data=%h face=%0d idx=%0d want data=%h face=%0d idx=%0d",
                                k, col_data0, rom_face0, rom_index0, {f[4:0], ix}, f, ix);
            end
            @(negedge clk);
            total++;
            if (wrap0 !== (k % 16 == 15)) begin
                bad++; $display("FAIL fwd_wrap col %0d got %b want %b", k, wrap0, (k % 16 == 15));
            end
        end
    endtask

    task automatic test_gap();
        bit ok; int tprev; logic [7:0] e;
        pulse_stop();
        rate = 16'd3; col_ready = 1'b1;
        pulse_start(5'd1);
        tprev = 0;
        for (int k = 0; k < 22; k++) begin
            e = ((k % 10) < 8) ? {5'd5, 3'(k % 10)} : 8'h00;
            wait_valid(1, ok);
            total++;
            if (!ok) begin bad++; $display("FAIL gap_timeout col %0d got valid=0 want 1", k); end
            if (k > 0) begin
                total++;
                if (cyc - tprev != 4) begin
                    bad++; $display("FAIL gap_rate col %0d got spacing %0d want 4", k, cyc - tprev);
                end
            end
            tprev = cyc;
            total++;
            if (col_data1 !== e) begin
                bad++; $display("FAIL gap_col %0d got %h want %h", k, col_data1, e);
            end
            @(negedge clk);
            total++;
            if (wrap1 !== (k % 10 == 9)) begin
                bad++; $display("FAIL gap_wrap col %0d got %b want %b", k, wrap1, (k % 10 == 9));
            end
        end
        rate = 16'd0;
    endtask

    task automatic test_stall();
        bit ok;
        pulse_stop();
        col_ready = 1'b0; rate = 16'd0;
        pulse_start(5'd2);
        wait_valid(0, ok);
        total++;
        if (!ok) begin bad++; $display("FAIL stall_timeout got valid=0 want 1"); end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            total++;
            if (col_data0 !== 8'h28 || col_valid0 !== 1'b1 || rom_index0 !== 3'd0) begin
                bad++; $display("FAIL stall_hold cyc %0d got data=%h v=%b idx=%0d want 28 1 0",
                                i, col_data0, col_valid0, rom_index0);
            end
        end
        total++;
        if (overrun0 !== 1'b1) begin bad++; $display("FAIL stall_overrun got %b want 1", overrun0); end
        col_ready = 1'b1;
        @(negedge clk);
        total++;
        if (col_valid0 !== 1'b0 || rom_index0 !== 3'd1) begin
            bad++; $display("FAIL stall_accept got v=%b idx=%0d want 0 1", col_valid0, rom_index0);
        end
        wait_valid(0, ok);
        total++;
        if (col_data0 !== 8'h29) begin bad++; $display("FAIL stall_resume got %h want 29", col_data0); end
        pulse_start(5'd2);
        total++;
        if (overrun0 !== 1'b0) begin bad++; $display("FAIL overrun_clear got %b want 0", overrun0); end
    endtask

    task automatic test_ctrl();
        bit ok;
        pulse_stop();
        total++;
        if (busy0 !== 1'b0) begin bad++; $display("FAIL stop_idle got busy=%b want 0", busy0); end
        pulse_start(5'd0);
        total++;
        if (busy0 !== 1'b0) begin bad++; $display("FAIL len0_ignored got busy=%b want 0", busy0); end
        pulse_start(5'd17);
        total++;
        if (busy0 !== 1'b0) begin bad++; $display("FAIL len17_ignored got busy=%b want 0", busy0); end
        col_ready = 1'b1;
        pulse_start(5'd2);
        total++;
        if (busy0 !== 1'b1) begin bad++; $display("FAIL start_run got busy=%b want 1", busy0); end
        repeat (7) @(negedge clk);
        pulse_start(5'd2);
        total++;
        if (col_valid0 !== 1'b0 || rom_index0 !== 3'd0) begin
            bad++; $display("FAIL restart got v=%b idx=%0d want 0 0", col_valid0, rom_index0);
        end
        wait_valid(0, ok);
        total++;
        if (col_data0 !== 8'h28) begin bad++; $display("FAIL restart_col got %h want 28", col_data0); end
        @(negedge clk); stop = 1'b1; start = 1'b1;
        @(negedge clk); stop = 1'b0; start = 1'b0;
        total++;
        if (busy0 !== 1'b0 || col_valid0 !== 1'b0 || rom_index0 !== 3'd0 || rom_face0 !== 6'd5) begin
            bad++; $display("FAIL stop_wins got busy=%b v=%b idx=%0d face=%0d want 0 0 0 5",
                            busy0, col_valid0, rom_index0, rom_face0);
        end
    endtask

`ifdef CHARSCROLL_REVERSE_EN
    task automatic test_reverse();
        bit ok; logic [5:0] f; logic [2:0] ix;
        pulse_stop();
        dir = 1'b1; rate = 16'd0; col_ready = 1'b1;
        pulse_start(5'd2);
        for (int k = 0; k < 20; k++) begin
            f = ((k % 16) < 8) ? 6'd9 : 6'd5;
            ix = 3'(7 - (k % 8));
            wait_valid(0, ok);
            total++;
            if (!ok || col_data0 !== {f[4:0], ix} || rom_face0 !== f || rom_index0 !== ix) begin
                bad++; $display("FAIL rev_col %0d got data=%h face=%0d idx=%0d want data=%h face=%0d idx=%0d",
                                k, col_data0, rom_face0, rom_index0, {f[4:0], ix}, f, ix);
            end
            @(negedge clk);
            total++;
            if (wrap0 !== (k % 16 == 15)) begin
                bad++; $display("FAIL rev_wrap col %0d got %b want %b", k, wrap0, (k % 16 == 15));
            end
        end
        dir = 1'b0;
    endtask
`endif

    task automatic test_reset_mid();
        bit ok;
        pulse_stop();
        col_ready = 1'b0; rate = 16'd0;
        pulse_start(5'd2);
        wait_valid(0, ok);
        repeat (2) @(negedge clk);
        total++;
        if (busy0 !== 1'b1 || overrun0 !== 1'b1) begin
            bad++; $display("FAIL pre_reset got busy=%b ovr=%b want 1 1", busy0, overrun0);
        end
        rst_n = 1'b0;
        #1;
        total++;
        if ({col_data0, col_valid0, busy0, wrap0, overrun0, rom_face0} !== '0) begin
            bad++; $display("FAIL reset_mid got data=%h v=%b busy=%b wrap=%b ovr=%b face=%h want all 0",
                            col_data0, col_valid0, busy0, wrap0, overrun0, rom_face0);
        end
        @(negedge clk); rst_n = 1'b1;
    endtask

    initial begin
        test_reset();
        test_forward();
        test_gap();
        test_stall();
        test_ctrl();
`ifdef CHARSCROLL_REVERSE_EN
        test_reverse();
`endif
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
